run_controller: RTL and testbench
=================================

RUN_CONTROLLER -- requirements
Module: run_controller

Interface
REQ-001 SHALL have parameter NUM_CORES, default 1: number of independently controlled CPU cores.
REQ-002 SHALL have parameter RST_CYCLES, default 2: core reset pulse length in clocks, legal range 1..255.
REQ-003 SHALL have parameter CNT_W, default 32: cycle counter and breakpoint width.
REQ-004 SHALL have port Clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port Reset  input  1  asynchronous, active-low block reset.
REQ-006 SHALL have port Start  input  1  level, one-cycle pulse: launch from IDLE or resume from HALT.
REQ-007 SHALL have port Stop  input  1  pulse: RUN -> HALT.
REQ-008 SHALL have port Step  input  1  pulse: one enabled cycle from HALT.
REQ-009 SHALL have port Soft_rst  input  1  pulse: re-run reset sequence for the cores.
REQ-010 SHALL have port Step_mode  input  1  0 = RESET exits to RUN; 1 = RESET exits to HALT.
REQ-011 SHALL have port Core_mask  input  NUM_CORES  cores to run, sampled on Start in IDLE and on Soft_rst.
REQ-012 SHALL have port Brk_en  input  1  cycle breakpoint enable.
REQ-013 SHALL have port Brk_cycle  input  CNT_W  breakpoint target in enabled cycles.
REQ-014 SHALL have port Core_reset  output  NUM_CORES  active-high reset to each core.
REQ-015 SHALL have port Core_enable  output  NUM_CORES  active-high clock enable to each core.
REQ-016 SHALL have port Cycle_count  output  CNT_W  enabled cycles delivered since last RESET.
REQ-017 SHALL have port State  output  3  encoded current state.
REQ-018 SHALL have port Brk_hit  output  1  sticky: halted by breakpoint.

Function
REQ-019 SHALL implement states IDLE=0, RESET=1, RUN=2, STEP=3, HALT=4.
REQ-020 SHALL enter RESET from IDLE on Start, from any non-IDLE state on Soft_rst; latch Core_mask; clear Cycle_count and Brk_hit.
REQ-021 SHALL stay in RESET exactly RST_CYCLES clocks, then go to HALT if Step_mode=1 or (Brk_en=1 and Brk_cycle=0), else RUN.
REQ-022 SHALL drive Core_reset=all ones in IDLE and RESET; otherwise Core_reset = ~latched mask.
REQ-023 SHALL drive Core_enable = latched mask in RUN and STEP, zero elsewhere (Moore decode of State).
REQ-024 SHALL increment Cycle_count on every edge where State is RUN or STEP, wrapping modulo 2^CNT_W.
REQ-025 SHALL in RUN go to HALT on Stop, or when Brk_en=1 and Cycle_count = Brk_cycle-1, setting Brk_hit on the breakpoint case; Cycle_count equals Brk_cycle on HALT entry.
REQ-026 SHALL in HALT go to STEP on Step, to RUN on Start (clearing Brk_hit); STEP always returns to HALT after one clock.
REQ-027 SHALL apply priority Soft_rst > Stop > breakpoint > Start > Step when inputs coincide; Start and Step together in HALT -> RUN.
REQ-028 SHALL ignore Stop/Step in IDLE, Start in RUN/STEP, and all inputs except Soft_rst in RESET.
REQ-029 SHALL treat Core_mask of zero as legal: sequencing proceeds, no core enabled, Cycle_count still increments.

Reset
REQ-030 SHALL on Reset=0, asynchronously: State=IDLE, Core_reset=all ones, Core_enable=0, Cycle_count=0, Brk_hit=0, latched mask=0.
REQ-031 SHALL resume from IDLE on the first rising edge after Reset deasserts; mid-operation assertion aborts immediately.

Structure
REQ-032 SHALL place state encodings and the State width constant in shared package run_ctrl_pkg.
REQ-033 SHALL implement the RESET-length counter as sub-module pulse_timer (parameter RST_CYCLES, load/done).

Verification
REQ-034 SHALL cover: NUM_CORES=2, mask=2'b11, Start -> Core_reset high 2 clocks, then Core_enable=2'b11, Cycle_count counts 1,2,3...
REQ-035 SHALL cover: Brk_en=1, Brk_cycle=5, Start -> exactly 5 enabled cycles, State=HALT, Cycle_count=5, Brk_hit=1.
REQ-036 SHALL cover: Step_mode=1, Start, then three Step pulses -> three single-cycle enables, Cycle_count=3, State=HALT.
REQ-037 SHALL cover: in RUN at count 10, Soft_rst and Stop same cycle -> RESET, Cycle_count=0, Core_reset all ones.
REQ-038 SHALL cover: CNT_W=4, free run 17 cycles -> Cycle_count wraps to 1; Reset=0 mid-RUN -> all outputs at reset values within same cycle.

Source files
------------

// File: rtl/run_ctrl_pkg.sv
// Shared state encoding and width constants for the CPU run controller.
package run_ctrl_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_RESET = 3'd1,
    ST_RUN   = 3'd2,
    ST_STEP  = 3'd3,
    ST_HALT  = 3'd4
  } run_state_e;

endpackage

// File: rtl/pulse_timer.sv
// Down-counter that times the core reset pulse; done is high on the last RESET clock.
module pulse_timer #(
  parameter int RST_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic done
);

  logic [7:0] cnt;

  // Loading RST_CYCLES-1 makes done assert in the final cycle of the pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= 8'(RST_CYCLES - 1);
    end else if (cnt != '0) begin
      cnt <= cnt - 8'd1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/run_controller.sv
// Sequences reset, run, single-step and halt for a group of CPU cores,
// with an enabled-cycle counter and an optional cycle breakpoint.
module run_controller
  import run_ctrl_pkg::*;
#(
  parameter int NUM_CORES  = 1,
  parameter int RST_CYCLES = 2,
  parameter int CNT_W      = 32
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic                 Stop,
  input  logic                 Step,
  input  logic                 Soft_rst,
  input  logic                 Step_mode,
  input  logic [NUM_CORES-1:0] Core_mask,
  input  logic                 Brk_en,
  input  logic [CNT_W-1:0]     Brk_cycle,
  output logic [NUM_CORES-1:0] Core_reset,
  output logic [NUM_CORES-1:0] Core_enable,
  output logic [CNT_W-1:0]     Cycle_count,
  output logic [STATE_W-1:0]   State,
  output logic                 Brk_hit
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  run_state_e           state_q, state_d;
  logic [NUM_CORES-1:0] mask_q;
  logic [CNT_W-1:0]     count_q;
  logic                 brk_q;
  logic                 enter_reset, set_brk, clr_brk;
  logic                 timer_done, brk_match, brk_zero;

  pulse_timer #(.RST_CYCLES(RST_CYCLES)) u_timer (
    .clk   (Clk),
    .rst_n (Reset),
    .load  (enter_reset),
    .done  (timer_done)
  );

  // The count increments on the same edge, so it lands exactly on Brk_cycle.
  assign brk_match = Brk_en && (count_q == (Brk_cycle - CNT_ONE));
  assign brk_zero  = Brk_en && (Brk_cycle == '0);

  always_comb begin
    state_d     = state_q;
    enter_reset = 1'b0;
    set_brk     = 1'b0;
    clr_brk     = 1'b0;
    if (Soft_rst && state_q != ST_IDLE) begin
      state_d     = ST_RESET;
      enter_reset = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (Start) begin
            state_d     = ST_RESET;
            enter_reset = 1'b1;
          end
        end
        ST_RESET: begin
          if (timer_done) begin
            if (Step_mode || brk_zero) begin
              state_d = ST_HALT;
              set_brk = brk_zero;
            end else begin
              state_d = ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (Stop) begin
            state_d = ST_HALT;
          end else if (brk_match) begin
            state_d = ST_HALT;
            set_brk = 1'b1;
          end
        end
        ST_STEP: state_d = ST_HALT;
        ST_HALT: begin
          if (Start) begin
            state_d = ST_RUN;
            clr_brk = 1'b1;
          end else if (Step) begin
            state_d = ST_STEP;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
      count_q <= '0;
      brk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (enter_reset) begin
        mask_q  <= Core_mask;
        count_q <= '0;
        brk_q   <= 1'b0;
      end else begin
        if (state_q == ST_RUN || state_q == ST_STEP) begin
          count_q <= count_q + CNT_ONE;
        end
        if (set_brk) begin
          brk_q <= 1'b1;
        end else if (clr_brk) begin
          brk_q <= 1'b0;
        end
      end
    end
  end

  assign Core_reset  = (state_q == ST_IDLE || state_q == ST_RESET) ? '1 : ~mask_q;
  assign Core_enable = (state_q == ST_RUN || state_q == ST_STEP) ? mask_q : '0;
  assign Cycle_count = count_q;
  assign State       = state_q;
  assign Brk_hit     = brk_q;

endmodule

// File: tb/tb_run_controller.sv
// Bench for run_controller: directed scenarios plus random pulses against a behavioural model.
module tb_run_controller;

  localparam int NC = 2;
  localparam int RC = 2;
  localparam int CW = 4;

  localparam int S_IDLE  = 0;
  localparam int S_RESET = 1;
  localparam int S_RUN   = 2;
  localparam int S_STEP  = 3;
  localparam int S_HALT  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, stop, step, soft_rst, step_mode, brk_en;
  logic [NC-1:0] core_mask;
  logic [CW-1:0] brk_cycle;
  logic [NC-1:0] core_reset, core_enable;
  logic [CW-1:0] cycle_count;
  logic [2:0]    state;
  logic          brk_hit;

  run_controller #(.NUM_CORES(NC), .RST_CYCLES(RC), .CNT_W(CW)) dut (
    .Clk         (clk),
    .Reset       (rst_n),
    .Start       (start),
    .Stop        (stop),
    .Step        (step),
    .Soft_rst    (soft_rst),
    .Step_mode   (step_mode),
    .Core_mask   (core_mask),
    .Brk_en      (brk_en),
    .Brk_cycle   (brk_cycle),
    .Core_reset  (core_reset),
    .Core_enable (core_enable),
    .Cycle_count (cycle_count),
    .State       (state),
    .Brk_hit     (brk_hit)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: state number, enabled-cycle count, latched mask, sticky flag.
  int m_state, m_cnt, m_rst_left, m_mask;
  bit m_brk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    int exp_rst, exp_en;
    exp_rst = (m_state == S_IDLE || m_state == S_RESET) ? 3 : ((~m_mask) & 3);
    exp_en  = (m_state == S_RUN || m_state == S_STEP) ? m_mask : 0;
    check("state", 32'(state), 32'(m_state));
    check("cycle_count", 32'(cycle_count), 32'(m_cnt));
    check("core_reset", 32'(core_reset), 32'(exp_rst));
    check("core_enable", 32'(core_enable), 32'(exp_en));
    check("brk_hit", 32'(brk_hit), 32'(m_brk));
  endtask

  task automatic model_reset();
    m_state = S_IDLE; m_cnt = 0; m_mask = 0; m_brk = 0; m_rst_left = 0;
  endtask

  task automatic model_enter_reset();
    m_state = S_RESET; m_rst_left = RC; m_cnt = 0; m_brk = 0; m_mask = int'(core_mask);
  endtask

  task automatic model_step(input bit st, input bit sp, input bit stp, input bit sr);
    int wrap, tgt;
    wrap = 1 << CW;
    tgt  = int'(brk_cycle);
    if (sr && m_state != S_IDLE) begin
      model_enter_reset();
    end else begin
      case (m_state)
        S_IDLE: if (st) model_enter_reset();
        S_RESET: begin
          m_rst_left--;
          if (m_rst_left == 0) begin
            if (step_mode || (brk_en && tgt == 0)) begin
              m_state = S_HALT;
              if (brk_en && tgt == 0) m_brk = 1;
            end else begin
              m_state = S_RUN;
            end
          end
        end
        S_RUN: begin
          m_cnt = (m_cnt + 1) % wrap;
          if (sp) m_state = S_HALT;
          else if (brk_en && m_cnt == tgt) begin
            m_state = S_HALT;
            m_brk   = 1;
          end
        end
        S_STEP: begin
          m_cnt   = (m_cnt + 1) % wrap;
          m_state = S_HALT;
        end
        S_HALT: begin
          if (st) begin
            m_state = S_RUN;
            m_brk   = 0;
          end else if (stp) begin
            m_state = S_STEP;
          end
        end
        default: m_state = S_IDLE;
      endcase
    end
  endtask

  // Called at a falling edge: apply pulses, advance the model, check at the next falling edge.
  task automatic drive(input bit st, input bit sp, input bit stp, input bit sr);
    start = st; stop = sp; step = stp; soft_rst = sr;
    model_step(st, sp, stp, sr);
    @(negedge clk);
    compare_all();
  endtask

  // Asserts the block reset mid-cycle and checks outputs before any clock edge.
  task automatic async_reset();
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    check("arst_core_reset", 32'(core_reset), 32'd3);
    check("arst_core_enable", 32'(core_enable), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    start = 0; stop = 0; step = 0; soft_rst = 0;
    compare_all();
  endtask

  initial begin
    int en_cnt;
    rst_n = 1'b0;
    start = 0; stop = 0; step = 0; soft_rst = 0; step_mode = 0;
    core_mask = '0; brk_en = 0; brk_cycle = '0;
    model_reset();
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;
    @(negedge clk);
    compare_all();

    // Launch with both cores: two reset clocks, then counting enables.
    core_mask = 2'b11;
    drive(1, 0, 0, 0);
    check("launch_reset", 32'(core_reset), 32'd3);
    drive(0, 0, 0, 0);
    check("launch_reset2", 32'(core_reset), 32'd3);
    drive(0, 0, 0, 0);
    check("launch_run", 32'(state), 32'd2);
    check("launch_enable", 32'(core_enable), 32'd3);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0);
    check("launch_count3", 32'(cycle_count), 32'd3);
    drive(0, 1, 0, 0);
    check("stop_halt", 32'(state), 32'd4);

    // Breakpoint after five enabled cycles.
    async_reset();
    brk_en = 1; brk_cycle = 4'd5;
    drive(1, 0, 0, 0);
    en_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      drive(0, 0, 0, 0);
      if (core_enable != '0) en_cnt++;
    end
    check("brk_enabled_cycles", 32'(en_cnt), 32'd5);
    check("brk_state", 32'(state), 32'd4);
    check("brk_count", 32'(cycle_count), 32'd5);
    check("brk_flag", 32'(brk_hit), 32'd1);

    // Step mode: three single-cycle enables.
    async_reset();
    brk_en = 0; step_mode = 1;
    drive(1, 0, 0, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    check("stepmode_halt", 32'(state), 32'd4);
    en_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 0);
      if (core_enable != '0) en_cnt++;
      drive(0, 0, 0, 0);
      if (core_enable != '0) en_cnt++;
    end
    check("step_enables", 32'(en_cnt), 32'd3);
    check("step_count", 32'(cycle_count), 32'd3);
    check("step_state", 32'(state), 32'd4);

    // Soft reset and Stop together at count 10: soft reset wins.
    async_reset();
    step_mode = 0;
    drive(1, 0, 0, 0);
    for (int i = 0; i < 40 && !(m_state == S_RUN && m_cnt == 10); i++) drive(0, 0, 0, 0);
    check("pre_soft_count", 32'(cycle_count), 32'd10);
    drive(0, 1, 0, 1);
    check("soft_state", 32'(state), 32'd1);
    check("soft_count", 32'(cycle_count), 32'd0);
    check("soft_core_reset", 32'(core_reset), 32'd3);

    // Free run past the counter width, then abort mid-run.
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    for (int i = 0; i < 17; i++) drive(0, 0, 0, 0);
    check("wrap_count", 32'(cycle_count), 32'd1);
    async_reset();
    check("arst_state", 32'(state), 32'd0);
    check("arst_count", 32'(cycle_count), 32'd0);

    // Random pulses and settings, with occasional block resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) step_mode = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) brk_en = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) brk_cycle = 4'($urandom_range(0, 15));
      core_mask = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0) begin
        async_reset();
      end else begin
        drive($urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0,
              $urandom_range(0, 4) == 0, $urandom_range(0, 39) == 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
